tcdm_bank_amo_adapter: RTL and testbench

Bank-side stage between the tile's TCDM slave request path and a single 1-cycle-latency SRAM bank. It accepts one TCDM slave request per cycle, executes plain reads/writes, atomic read-modify-write (AMO) and LR/SC, and returns responses through a small response FIFO. The SRAM macro is directly downstream; the tile's response crossbar is directly downstream of the response port.

---
 rtl/tcdm_bank_amo_adapter.sv | 177 +++++++++++++++++
 tb/tb_tcdm_bank_amo_adapter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tcdm_bank_amo_adapter.sv
// TCDM bank adapter: plain R/W, AMO read-modify-write and LR/SC in front of a 1-cycle SRAM.
// Define MEMPOOL_LRSC_EN to enable the LR/SC reservation register.
module tcdm_bank_amo_adapter #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned MetaWidth = 12,
  parameter int unsigned RespDepth = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [AddrWidth-1:0]   in_addr_i,
  input  logic                   in_wen_i,
  input  logic [DataWidth/8-1:0] in_be_i,
  input  logic [DataWidth-1:0]   in_data_i,
  input  logic [3:0]             in_amo_i,
  input  logic [MetaWidth-1:0]   in_meta_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DataWidth-1:0]   out_data_o,
  output logic [MetaWidth-1:0]   out_meta_o,
  output logic                   sram_req_o,
  output logic                   sram_we_o,
  output logic [AddrWidth-1:0]   sram_addr_o,
  output logic [DataWidth-1:0]   sram_wdata_o,
  output logic [DataWidth/8-1:0] sram_be_o,
  input  logic [DataWidth-1:0]   sram_rdata_i
);
  localparam int unsigned PtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam int unsigned CntW = $clog2(RespDepth + 1);

  typedef enum logic {IDLE, AMO_WR} state_e;
  state_e state_q, state_d;

  logic [3:0] op;
  logic is_amo, is_lr, is_sc, accept, sc_ok;
  assign op     = (in_amo_i >= 4'hC) ? 4'h0 : in_amo_i;
  assign is_amo = (op != 4'h0) && (op <= 4'h9);
  assign is_lr  = (op == 4'hA);
  assign is_sc  = (op == 4'hB);
  assign accept = in_valid_i && in_ready_o;

  logic [3:0]           amo_op_q;
  logic [DataWidth-1:0] amo_opnd_q, amo_res;
  logic [AddrWidth-1:0] amo_addr_q;
  // A response is due next cycle: data from SRAM (read/LR/AMO) or the SC status bit
  logic                 pend_q, pend_rd_q, pend_sc_q;
  logic [MetaWidth-1:0] pend_meta_q;

  logic [DataWidth-1:0] fdata_q [RespDepth];
  logic [MetaWidth-1:0] fmeta_q [RespDepth];
  logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]      cnt_q;

`ifdef MEMPOOL_LRSC_EN
  logic                 res_valid_q;
  logic [AddrWidth-1:0] res_addr_q;
  logic [MetaWidth-1:0] res_meta_q;
  assign sc_ok = res_valid_q && (res_addr_q == in_addr_i) && (res_meta_q == in_meta_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_valid_q <= 1'b0;
      res_addr_q  <= '0;
      res_meta_q  <= '0;
    end else if (state_q == IDLE && accept && is_lr) begin
      res_valid_q <= 1'b1;
      res_addr_q  <= in_addr_i;
      res_meta_q  <= in_meta_i;
    end else if (sram_req_o && sram_we_o && sram_addr_o == res_addr_q) begin
      res_valid_q <= 1'b0;
    end
  end
`else
  // Without reservations SC is an unconditional write that reports success
  assign sc_ok = 1'b1;
`endif

  always_comb begin
    case (amo_op_q)
      4'h1:    amo_res = amo_opnd_q;
      4'h2:    amo_res = sram_rdata_i + amo_opnd_q;
      4'h3:    amo_res = sram_rdata_i & amo_opnd_q;
      4'h4:    amo_res = sram_rdata_i | amo_opnd_q;
      4'h5:    amo_res = sram_rdata_i ^ amo_opnd_q;
      4'h6:    amo_res = ($signed(sram_rdata_i) > $signed(amo_opnd_q)) ? sram_rdata_i : amo_opnd_q;
      4'h7:    amo_res = (sram_rdata_i > amo_opnd_q) ? sram_rdata_i : amo_opnd_q;
      4'h8:    amo_res = ($signed(sram_rdata_i) < $signed(amo_opnd_q)) ? sram_rdata_i : amo_opnd_q;
      4'h9:    amo_res = (sram_rdata_i < amo_opnd_q) ? sram_rdata_i : amo_opnd_q;
      default: amo_res = sram_rdata_i;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = in_addr_i;
    sram_wdata_o = in_data_i;
    sram_be_o    = in_be_i;
    if (state_q == AMO_WR) begin
      sram_req_o   = 1'b1;
      sram_we_o    = 1'b1;
      sram_addr_o  = amo_addr_q;
      sram_wdata_o = amo_res;
      sram_be_o    = '1;
      state_d      = IDLE;
    end else if (accept) begin
      sram_req_o = is_sc ? sc_ok : 1'b1;
      sram_we_o  = is_sc ? sc_ok : (!is_amo && !is_lr && in_wen_i);
      if (is_amo) state_d = AMO_WR;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      amo_op_q    <= '0;
      amo_opnd_q  <= '0;
      amo_addr_q  <= '0;
      pend_q      <= 1'b0;
      pend_rd_q   <= 1'b0;
      pend_sc_q   <= 1'b0;
      pend_meta_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= (state_q == IDLE) && accept && (is_amo || is_lr || is_sc || !in_wen_i);
      if (state_q == IDLE && accept) begin
        amo_op_q    <= op;
        amo_opnd_q  <= in_data_i;
        amo_addr_q  <= in_addr_i;
        pend_rd_q   <= !is_sc;
        pend_sc_q   <= !sc_ok;
        pend_meta_q <= in_meta_i;
      end
    end
  end

  // Response FIFO with fall-through when empty
  logic                 push, pop, store, deq, empty;
  logic [DataWidth-1:0] push_data;
  assign push      = pend_q;
  assign push_data = pend_rd_q ? sram_rdata_i : {{(DataWidth-1){1'b0}}, pend_sc_q};
  assign empty     = (cnt_q == '0);
  assign out_valid_o = !empty || push;
  assign out_data_o  = empty ? push_data   : fdata_q[rd_ptr_q];
  assign out_meta_o  = empty ? pend_meta_q : fmeta_q[rd_ptr_q];
  assign pop   = out_valid_o && out_ready_i;
  assign store = push && !(empty && pop);
  assign deq   = pop && !empty;
  assign in_ready_o = (state_q == IDLE) &&
                      (({1'b0, cnt_q} + {{CntW{1'b0}}, pend_q}) < (CntW+1)'(RespDepth));

  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return (p == PtrW'(RespDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (store) wr_ptr_q <= nxt(wr_ptr_q);
      if (deq)   rd_ptr_q <= nxt(rd_ptr_q);
      cnt_q <= cnt_q + CntW'(store) - CntW'(deq);
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) begin
      fdata_q[wr_ptr_q] <= push_data;
      fmeta_q[wr_ptr_q] <= pend_meta_q;
    end
  end
endmodule

// File: tb/tb_tcdm_bank_amo_adapter.sv
// Directed bench for tcdm_bank_amo_adapter with a behavioural 1-cycle SRAM model.
module tb_tcdm_bank_amo_adapter;
  logic        clk = 1'b0, rst;
  logic        in_valid, in_ready, in_wen, out_valid, out_ready;
  logic [7:0]  in_addr, sram_addr;
  logic [3:0]  in_be, in_amo, sram_be;
  logic [31:0] in_data, out_data, sram_wdata, sram_rdata;
  logic [11:0] in_meta, out_meta;
  logic        sram_req, sram_we;
  logic [31:0] mem [256];
  logic        s_rdy, s_req, s_we;
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  tcdm_bank_amo_adapter dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_addr_i(in_addr), .in_wen_i(in_wen),
    .in_be_i(in_be), .in_data_i(in_data), .in_amo_i(in_amo), .in_meta_i(in_meta),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_meta_o(out_meta),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
  );

  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Present one request for a single cycle; called and returns at posedge+1
  task automatic op(input logic [3:0] amo, input logic wen, input logic [7:0] addr,
                    input logic [31:0] data, input logic [3:0] be, input logic [11:0] meta);
    in_valid = 1'b1; in_amo = amo; in_wen = wen; in_addr = addr;
    in_data = data; in_be = be; in_meta = meta;
    @(negedge clk);
    s_rdy = in_ready; s_req = sram_req; s_we = sram_we;
    @(posedge clk); #1;
    in_valid = 1'b0; in_amo = 4'h0; in_wen = 1'b0;
  endtask

  task automatic rsp(input string tag, input logic [31:0] d, input logic [11:0] m);
    @(negedge clk);
    chk({tag, "_v"}, out_valid, 1);
    chk(tag, out_data, d);
    chk({tag, "_m"}, out_meta, m);
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    op(4'h0, 1'b1, addr, data, 4'hF, 12'h0);
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    op(4'h0, 1'b0, addr, 32'h0, 4'h0, 12'h0AB);
    rsp(tag, exp, 12'h0AB);
  endtask

  logic [31:0] amo_exp [1:9];

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    amo_exp[1] = 32'hF00000FF; amo_exp[2] = 32'hFF0F01EF; amo_exp[3] = 32'h000000F0;
    amo_exp[4] = 32'hFF0F00FF; amo_exp[5] = 32'hFF0F000F; amo_exp[6] = 32'h0F0F00F0;
    amo_exp[7] = 32'hF00000FF; amo_exp[8] = 32'hF00000FF; amo_exp[9] = 32'h0F0F00F0;
    rst = 1'b1; in_valid = 0; in_wen = 0; in_addr = 0; in_be = 0; in_data = 0;
    in_amo = 0; in_meta = 0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sram_req", sram_req, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_sram_we", sram_we, 0);
    @(posedge clk); #1;

    // Plain write then read
    op(4'h0, 1'b1, 8'd5, 32'h1234_5678, 4'hF, 12'h001);
    chk("wr_req", s_req, 1); chk("wr_we", s_we, 1);
    @(negedge clk); chk("wr_no_rsp", out_valid, 0);
    @(posedge clk); #1;
    op(4'h0, 1'b0, 8'd5, 32'h0, 4'h0, 12'h055);
    chk("rd_we", s_we, 0);
    rsp("rd5", 32'h1234_5678, 12'h055);

    // AMO ADD wrap
    wr(8'd3, 32'hFFFF_FFFF);
    op(4'h2, 1'b0, 8'd3, 32'h1, 4'h0, 12'h077);
    chk("add_acc_rdy", s_rdy, 1);
    @(negedge clk);
    chk("add_busy", in_ready, 0);
    chk("add_we", sram_we, 1);
    chk("add_wdata", sram_wdata, 32'h0);
    chk("add_old", out_data, 32'hFFFF_FFFF);
    chk("add_meta", out_meta, 12'h077);
    @(posedge clk); #1;
    rd("add_rd", 8'd3, 32'h0);

    // MAX signed vs MAXU
    wr(8'd9, 32'h8000_0000);
    op(4'h6, 1'b0, 8'd9, 32'h1, 4'h0, 12'h009);
    rsp("max_old", 32'h8000_0000, 12'h009);
    rd("max_rd", 8'd9, 32'h0000_0001);
    wr(8'd9, 32'h8000_0000);
    op(4'h7, 1'b0, 8'd9, 32'h1, 4'h0, 12'h009);
    rsp("maxu_old", 32'h8000_0000, 12'h009);
    rd("maxu_rd", 8'd9, 32'h8000_0000);

    // Every AMO op: 0x0F0F00F0 op 0xF00000FF
    for (int k = 1; k <= 9; k++) begin
      wr(8'd10, 32'h0F0F_00F0);
      op(4'(k), 1'b1, 8'd10, 32'hF000_00FF, 4'h0, 12'(k));
      rsp($sformatf("amo%0d_old", k), 32'h0F0F_00F0, 12'(k));
      rd($sformatf("amo%0d_rd", k), 8'd10, amo_exp[k]);
    end

    // Backpressure: only two reads fit
    out_ready = 1'b0;
    op(4'h0, 1'b0, 8'd5, 0, 0, 12'h001); chk("bp_rdy1", s_rdy, 1);
    op(4'h0, 1'b0, 8'd3, 0, 0, 12'h002); chk("bp_rdy2", s_rdy, 1);
    op(4'h0, 1'b0, 8'd5, 0, 0, 12'h003); chk("bp_rdy3", s_rdy, 0);
    @(negedge clk);
    chk("bp_v", out_valid, 1); chk("bp_m1", out_meta, 12'h001);
    chk("bp_d1", out_data, 32'h1234_5678); chk("bp_busy", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("bp_hold", out_meta, 12'h001);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_m2", out_meta, 12'h002); chk("bp_d2", out_data, 32'h0);
    chk("bp_rdy_again", in_ready, 1);
    @(posedge clk); #1;
    @(negedge clk); chk("bp_drained", out_valid, 0);
    @(posedge clk); #1;

    // LR/SC
    op(4'hA, 1'b0, 8'd7, 0, 0, 12'h02A);
    rsp("lr1", 32'h0, 12'h02A);
    op(4'hB, 1'b0, 8'd7, 32'hCAFE_F00D, 4'hF, 12'h02A);
    chk("sc1_req", s_req, 1);
    rsp("sc1", 32'h0, 12'h02A);
    rd("sc1_rd", 8'd7, 32'hCAFE_F00D);
    op(4'hA, 1'b0, 8'd7, 0, 0, 12'h02A);
    rsp("lr2", 32'hCAFE_F00D, 12'h02A);
    wr(8'd7, 32'h1111_1111);
    op(4'hB, 1'b0, 8'd7, 32'h2222_2222, 4'hF, 12'h02A);
`ifdef MEMPOOL_LRSC_EN
    chk("sc2_req", s_req, 0);
    rsp("sc2", 32'h1, 12'h02A);
    rd("sc2_rd", 8'd7, 32'h1111_1111);
`else
    chk("sc2_req", s_req, 1);
    rsp("sc2", 32'h0, 12'h02A);
    rd("sc2_rd", 8'd7, 32'h2222_2222);
`endif

    // Reset during AMO_WR
    op(4'hA, 1'b0, 8'd12, 0, 0, 12'h003);
    rsp("lr3", 32'h0, 12'h003);
    wr(8'd13, 32'h5);
    op(4'h2, 1'b0, 8'd13, 32'h1, 4'h0, 12'h033);
    rst = 1'b1;
    @(negedge clk);
    chk("rstamo_req", sram_req, 0);
    chk("rstamo_we", sram_we, 0);
    chk("rstamo_v", out_valid, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); chk("rstamo_rdy", in_ready, 1);
    @(posedge clk); #1;
    rd("rstamo_rd", 8'd13, 32'h5);
    op(4'hB, 1'b0, 8'd12, 32'h9, 4'hF, 12'h003);
`ifdef MEMPOOL_LRSC_EN
    rsp("rst_sc", 32'h1, 12'h003);
`else
    rsp("rst_sc", 32'h0, 12'h003);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
